// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the tagged register file:
//     - default parameter constants (data width, entry count, tag width,
//       read-port count, zero-register enable)
//     - clr_state_e : clear-sequencer state encoding (IDLE, CLEAR)
//     - entry_t     : one register-file entry {data, tag} at default widths
//   Optional feature macro used by the top: TAGGED_REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int TAG_W_DEF    = 4;
    localparam int NRD_DEF      = 2;
    localparam int ZERO_REG_DEF = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Entry layout at default widths; the top declares the same
    // {data, tag} layout at its own parameterised widths.
    typedef struct packed {
        logic [XLEN_DEF-1:0]  data;
        logic [TAG_W_DEF-1:0] tag;
    } entry_t;

endpackage : regfile_pkg

// File: rtl/regfile_clr_seq.sv
// ---------------------------------------------------------------------------
// regfile_clr_seq
//   Clear sequencer: a two-state FSM (IDLE/CLEAR) plus a sweep index that
//   zeroes one register-file entry per cycle, index 0 first, NREGS cycles.
//
// Ports
//   clk_i      in   clock, rising edge
//   reset      in   synchronous active-high reset
//   clr_req_i  in   start a sweep (sampled only while IDLE)
//   busy_o     out  sweep in progress (high exactly NREGS cycles)
//   clr_en_o   out  clear the entry at clr_idx_o on this edge
//   clr_idx_o  out  entry being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_idx_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    clr_state_e    r_state;
    logic [AW-1:0] r_idx;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // A request in IDLE starts the sweep next cycle; a held
                    // level re-triggers from here after each sweep ends.
                    if (clr_req_i) begin
                        r_state <= CLEAR;
                    end
                    r_idx <= '0;
                end
                CLEAR: begin
                    // Requests are ignored while sweeping.
                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy_o    = (r_state == CLEAR);
    assign clr_en_o  = (r_state == CLEAR);
    assign clr_idx_o = r_idx;

endmodule : regfile_clr_seq

// File: rtl/tagged_regfile.sv
// ---------------------------------------------------------------------------
// tagged_regfile
//   Register file of NREGS entries, each holding XLEN data bits plus a
//   TAG_W-bit tag. NRD combinational read ports plus one debug read port,
//   one write port, and a full-file clear sweep run by regfile_clr_seq.
//   With ZERO_REG=1 entry 0 reads as zero and silently ignores writes.
//
//   Optional feature: define TAGGED_REGFILE_BYPASS_EN to forward an
//   accepted write to any matching read port in the same cycle (the debug
//   port never bypasses). Undefined: reads see pre-write contents.
//
// Ports
//   clk_i       in   clock, rising edge
//   reset       in   synchronous active-high reset (zeroes all entries)
//   rd_addr_i   in   NRD*AW   packed read addresses, port k at [k*AW +: AW]
//   rd_data_o   out  NRD*XLEN packed read data
//   rd_tag_o    out  NRD*TAG_W packed read tags
//   dbg_addr_i  in   AW       debug read address
//   dbg_data_o  out  XLEN     debug read data
//   dbg_tag_o   out  TAG_W    debug read tag
//   wr_en_i     in   write enable
//   wr_addr_i   in   write address
//   wr_data_i   in   write data
//   wr_tag_i    in   write tag
//   clr_req_i   in   start clear sweep
//   busy_o      out  clear sweep in progress
//   wr_drop_o   out  write presented while busy and discarded
// ---------------------------------------------------------------------------
module tagged_regfile
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int TAG_W    = TAG_W_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int ZERO_REG = ZERO_REG_DEF,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD*TAG_W-1:0] rd_tag_o,
    input  logic [AW-1:0]        dbg_addr_i,
    output logic [XLEN-1:0]      dbg_data_o,
    output logic [TAG_W-1:0]     dbg_tag_o,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [XLEN-1:0]      wr_data_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic                 clr_req_i,
    output logic                 busy_o,
    output logic                 wr_drop_o
);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } rf_entry_t;

    rf_entry_t     r_mem [NREGS];

    logic          w_busy;
    logic          w_clr_en;
    logic [AW-1:0] w_clr_idx;
    logic          w_wr_zero;
    logic          w_wr_ok;
    rf_entry_t     w_wr_ent;
    rf_entry_t     w_dbg_ent;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    regfile_clr_seq #(
        .NREGS (NREGS)
    ) u_clr_seq (
        .clk_i     (clk_i),
        .reset     (reset),
        .clr_req_i (clr_req_i),
        .busy_o    (w_busy),
        .clr_en_o  (w_clr_en),
        .clr_idx_o (w_clr_idx)
    );

    // ---------------------------------------------------------------
    // Write qualification
    // ---------------------------------------------------------------
    // Entry 0 writes are swallowed quietly (not a drop); writes during a
    // sweep are dropped and flagged. Reset suppresses both.
    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);
    assign w_wr_ok   = wr_en_i && !w_busy && !reset && !w_wr_zero;
    assign wr_drop_o = wr_en_i && w_busy && !reset;
    assign busy_o    = w_busy;
    assign w_wr_ent  = '{data: wr_data_i, tag: wr_tag_i};

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    // Sweep and write are mutually exclusive (writes need !busy), so the
    // priority order below only matters for reset.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr_i] <= w_wr_ent;
        end
    end

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        rf_entry_t     w_ent;

        assign w_addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            w_ent = r_mem[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_ent = '0;
            end
`ifdef TAGGED_REGFILE_BYPASS_EN
            // w_wr_ok already excludes entry 0 and busy/reset cycles.
            if (w_wr_ok && (w_addr == wr_addr_i)) begin
                w_ent = w_wr_ent;
            end
`endif
        end

        assign rd_data_o[k*XLEN +: XLEN]  = w_ent.data;
        assign rd_tag_o[k*TAG_W +: TAG_W] = w_ent.tag;
    end

    // Debug port: plain array read, never bypassed.
    always_comb begin
        w_dbg_ent = r_mem[dbg_addr_i];
        if ((ZERO_REG != 0) && (dbg_addr_i == '0)) begin
            w_dbg_ent = '0;
        end
    end

    assign dbg_data_o = w_dbg_ent.data;
    assign dbg_tag_o  = w_dbg_ent.tag;

endmodule : tagged_regfile

// File: tb/tb_tagged_regfile.sv
// ---------------------------------------------------------------------------
// tb_tagged_regfile
//   Self-checking bench for tagged_regfile at default parameters. The
//   reference model is a plain array plus a "sweep position" integer
//   (-1 when no sweep is running); every cycle all outputs are compared
//   against it, with directed scenarios for the documented corner cases.
// ---------------------------------------------------------------------------
module tb_tagged_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef TAGGED_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AW-1:0]        rd0, rd1;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic [AW-1:0]        dbg_addr;
    logic [XLEN-1:0]      dbg_data;
    logic [TAG_W-1:0]     dbg_tag;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic [TAG_W-1:0]     wr_tag;
    logic                 clr_req;
    logic                 busy;
    logic                 wr_drop;

    assign rd_addr = {rd1, rd0};

    always #5 clk = ~clk;

    tagged_regfile dut (
        .clk_i      (clk),
        .reset      (reset),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_tag_o   (rd_tag),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .dbg_tag_o  (dbg_tag),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_tag_i   (wr_tag),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .wr_drop_o  (wr_drop)
    );

    // Reference model
    logic [XLEN-1:0]  m_data [NREGS];
    logic [TAG_W-1:0] m_tag  [NREGS];
    int               m_sweep = -1;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN+TAG_W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp_ok);
        logic acc;
        acc = !reset && wr_en && (m_sweep < 0) && (wr_addr != 0);
        if (byp_ok && BYP && acc && (a == wr_addr))
            return {wr_data, wr_tag};
        return {m_data[a], m_tag[a]};
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_data[i] = '0;
                m_tag[i]  = '0;
            end
            m_sweep = -1;
        end else if (m_sweep >= 0) begin
            m_data[m_sweep] = '0;
            m_tag[m_sweep]  = '0;
            m_sweep++;
            if (m_sweep == NREGS) m_sweep = -1;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_data[wr_addr] = wr_data;
                m_tag[wr_addr]  = wr_tag;
            end
            if (clr_req) m_sweep = 0;
        end
    endtask

    // One clock: check all outputs against the model before the edge,
    // then advance the model with the same inputs.
    task automatic cyc();
        logic [XLEN+TAG_W-1:0] e;
        #2;
        if (chk_on) begin
            chk("busy", {63'd0, busy}, {63'd0, m_sweep >= 0});
            chk("wr_drop", {63'd0, wr_drop}, {63'd0, wr_en && (m_sweep >= 0) && !reset});
            e = exp_rd(rd0, 1'b1);
            chk("rd0", {28'd0, rd_data[31:0], rd_tag[3:0]}, {28'd0, e});
            e = exp_rd(rd1, 1'b1);
            chk("rd1", {28'd0, rd_data[63:32], rd_tag[7:4]}, {28'd0, e});
            e = exp_rd(dbg_addr, 1'b0);
            chk("dbg", {28'd0, dbg_data, dbg_tag}, {28'd0, e});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_rd();
        rd0      = AW'($urandom);
        rd1      = AW'($urandom);
        dbg_addr = AW'($urandom);
    endtask

    task automatic idle_in();
        reset = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_tag = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic [TAG_W-1:0] t);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_tag = t;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;

        idle_in();
        rand_rd();
        reset = 1'b1;
        cyc();              // DUT state unknown before the first reset edge
        chk_on = 1'b1;
        cyc();              // second reset cycle, checked
        reset = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_drop", {63'd0, wr_drop}, 64'd0);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk("rst_zero", {28'd0, dbg_data, dbg_tag}, 64'd0);
        end

        // Basic write/read at entry 5
        do_write(5'd5, 32'hDEADBEEF, 4'h3);
        rd0 = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("w5_rd0", {28'd0, rd_data[31:0], rd_tag[3:0]}, {28'd0, 32'hDEADBEEF, 4'h3});
        chk("w5_dbg", {28'd0, dbg_data, dbg_tag}, {28'd0, 32'hDEADBEEF, 4'h3});
        cyc();

        // Entry 0 is hardwired: write ignored, no drop
        rd0 = 5'd0; rd1 = 5'd0; dbg_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; wr_tag = 4'h7;
        #1;
        chk("w0_drop", {63'd0, wr_drop}, 64'd0);
        cyc();
        wr_en = 1'b0;
        #1;
        chk("w0_rd", {28'd0, rd_data[31:0], rd_tag[3:0]}, 64'd0);
        cyc();

        // Random traffic, occasional clear requests
        for (int n = 0; n < 120; n++) begin
            rand_rd();
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            wr_tag  = TAG_W'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle_in();
        guard = 0;
        while (m_sweep >= 0 && guard < 100) begin
            rand_rd(); cyc(); guard++;
        end

        // Fill all entries, pulse clear, write entry 7 on the 3rd busy cycle
        for (int i = 1; i < NREGS; i++) begin
            rand_rd();
            do_write(AW'(i), $urandom | 32'h1, TAG_W'($urandom));
        end
        clr_req = 1'b1; cyc(); clr_req = 1'b0;
        cnt = 0; guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            cnt++; guard++;
            rand_rd();
            if (cnt == 3) begin
                wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; wr_tag = 4'h9;
                #1;
                chk("drop_pulse", {63'd0, wr_drop}, 64'd1);
            end
            cyc();
            wr_en = 1'b0;
        end
        chk("busy_len", 64'(cnt), 64'd32);
        rd0 = 5'd7; #1;
        chk("addr7_cleared", {28'd0, rd_data[31:0], rd_tag[3:0]}, 64'd0);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk("swept_zero", {28'd0, dbg_data, dbg_tag}, 64'd0);
        end
        cyc();

        // Simultaneous write + clear in IDLE: write lands, then gets swept
        rd0 = 5'd12;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BADCAFE; wr_tag = 4'hE; clr_req = 1'b1;
        cyc();
        idle_in();
        #1;
        chk("sim_busy", {63'd0, busy}, 64'd1);
        chk("sim_written", {28'd0, rd_data[31:0], rd_tag[3:0]}, {28'd0, 32'h0BADCAFE, 4'hE});
        guard = 0;
        while (m_sweep >= 0 && guard < 100) begin
            cyc(); guard++;
        end
        chk("sim_cleared", {28'd0, rd_data[31:0], rd_tag[3:0]}, 64'd0);

        // Held clear level: back-to-back sweeps with one idle cycle between
        clr_req = 1'b1;
        for (int n = 0; n < 70; n++) begin
            rand_rd();
            wr_en = ($urandom_range(0, 2) == 0);
            wr_addr = AW'($urandom); wr_data = $urandom; wr_tag = TAG_W'($urandom);
            cyc();
        end
        idle_in();
        guard = 0;
        while (m_sweep >= 0 && guard < 100) begin
            cyc(); guard++;
        end

        // Reset in the middle of a sweep (index 10) overrides write/clear
        for (int i = 1; i < NREGS; i++) do_write(AW'(i), 32'h5A000000 | 32'(i), 4'h5);
        clr_req = 1'b1; cyc(); clr_req = 1'b0;
        guard = 0;
        while (m_sweep != 10 && guard < 100) begin
            rand_rd(); cyc(); guard++;
        end
        chk("reach_idx10", 64'(m_sweep), 64'd10);
        reset = 1'b1; clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33333333; wr_tag = 4'h3;
        cyc();
        idle_in();
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk("rst_mid_zero", {28'd0, dbg_data, dbg_tag}, 64'd0);
        end
        do_write(5'd3, 32'h76543210, 4'hC);
        rd1 = 5'd3; #1;
        chk("post_rst_wr", {28'd0, rd_data[63:32], rd_tag[7:4]}, {28'd0, 32'h76543210, 4'hC});
        cyc();

        // Same-cycle read of an entry being written
        do_write(5'd9, 32'h11111111, 4'h1);
        rd1 = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; wr_tag = 4'hA;
        #1;
        chk("bypass_rd1", {32'd0, rd_data[63:32]}, BYP ? 64'hA5A5A5A5 : 64'h11111111);
        dbg_addr = 5'd9; #1;
        chk("dbg_nobyp", {32'd0, dbg_data}, 64'h11111111);
        cyc();
        wr_en = 1'b0;
        #1;
        chk("rd9_after", {32'd0, rd_data[63:32]}, 64'hA5A5A5A5);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_tagged_regfile

// File: doc/tagged_regfile.md
TAGGED_REGFILE -- requirements
Module: tagged_regfile

Interface
REQ-001 Parameter XLEN, default 32: data width per entry.
REQ-002 Parameter NREGS, default 32: entry count, power of two, at least 4; AW = log2(NREGS).
REQ-003 Parameter TAG_W, default 4: per-entry tag (position) width.
REQ-004 Parameter NRD, default 2: number of read ports.
REQ-005 Parameter ZERO_REG, default 1: 1 = entry 0 hardwired to zero data and zero tag.
REQ-006 Clocking and reset SHALL be one clock, clk_i; reset is synchronous and active-high, port reset.
REQ-007 clk_i  in  1  clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 rd_addr_i  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-010 rd_data_o  out  NRD*XLEN  packed read data.
REQ-011 rd_tag_o  out  NRD*TAG_W  packed read tags.
REQ-012 dbg_addr_i  in  AW  debug/observe address.
REQ-013 dbg_data_o  out  XLEN  entry data at dbg_addr_i.
REQ-014 dbg_tag_o  out  TAG_W  entry tag at dbg_addr_i.
REQ-015 wr_en_i  in  1  write enable.
REQ-016 wr_addr_i  in  AW  write address.
REQ-017 wr_data_i  in  XLEN  write data.
REQ-018 wr_tag_i  in  TAG_W  write tag.
REQ-019 clr_req_i  in  1  start a full-file clear sweep (pulse or level).
REQ-020 busy_o  out  1  clear sweep in progress.
REQ-021 wr_drop_o  out  1  one-cycle pulse: write accepted at port but discarded.

Function
REQ-022 Reads SHALL be combinational from array state; dbg port behaves as one extra read port with no bypass.
REQ-023 With wr_en_i=1, not busy and writable address, data and tag SHALL update at the next rising edge.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be ignored without wr_drop_o; reads of 0 SHALL return 0 data and 0 tag.
REQ-025 FSM states IDLE and CLEAR; IDLE->CLEAR when clr_req_i=1; CLEAR->IDLE after index NREGS-1 is cleared.
REQ-026 In CLEAR, the sweep index SHALL start at 0 and zero one entry (data and tag) per cycle; busy_o=1 for exactly NREGS cycles.
REQ-027 clr_req_i while busy SHALL be ignored; a level held high past the sweep end SHALL start a new sweep the following cycle.
REQ-028 Writes while busy_o=1 SHALL be discarded and SHALL pulse wr_drop_o the same cycle.
REQ-029 Reads during CLEAR SHALL return current array contents; entries below the sweep index read zero.
REQ-030 Simultaneous clr_req_i and wr_en_i in IDLE: the write SHALL complete and the sweep SHALL start the next cycle, clearing that write.

Reset
REQ-031 On reset, all entries (data and tag) SHALL be zero after one edge; FSM=IDLE, sweep index=0, busy_o=0, wr_drop_o=0.
REQ-032 Reset mid-sweep SHALL abort the sweep and take priority over every write and clear request.

Configuration
REQ-033 Macro TAGGED_REGFILE_BYPASS_EN defined: a read port whose address equals wr_addr_i, with a write being accepted this cycle, SHALL return wr_data_i/wr_tag_i combinationally.
REQ-034 Macro not defined: reads SHALL return pre-write array contents until the edge; no bypass logic is generated.

Structure
REQ-035 Shared package regfile_pkg SHALL hold default parameter constants, the FSM state enum (IDLE, CLEAR) and the entry struct {data, tag}.
REQ-036 The clear sequencer (FSM plus sweep counter) SHALL be a sub-module, regfile_clr_seq.

Verification
REQ-037 Reset, write addr 5 data 0xDEADBEEF tag 0x3 -> next cycle port0 addr 5 reads 0xDEADBEEF/0x3; dbg addr 5 matches.
REQ-038 Write addr 0 data 0x1234 (ZERO_REG=1) -> addr 0 reads 0/0; wr_drop_o stays 0.
REQ-039 Fill all entries, pulse clr_req_i -> busy_o high exactly 32 cycles; afterwards all entries read 0.
REQ-040 Write addr 7 on the 3rd busy cycle -> wr_drop_o pulses; addr 7 reads 0 after the sweep.
REQ-041 With bypass macro defined, write addr 9 data 0xA5A5A5A5 while port1 reads addr 9 -> same-cycle rd_data 0xA5A5A5A5; without macro -> old value.
REQ-042 Assert reset at sweep index 10 -> busy_o=0 next cycle; all entries 0; a subsequent write succeeds.
